// File: rtl/updatey_writeback.sv
// Write-back stage for the change-in-Y datapath: buffers {addr, Y} pairs in a small FIFO and
// drains them to Y-matrix memory one write at a time, flagging completion of each pass.
module updatey_writeback #(
    parameter int unsigned DATA_W = 48,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  expected_count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              in_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  wr_count,
    output logic              overflow,
    output logic              all_done
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef enum logic {StIdle = 1'b0, StWrite = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [CNT_W-1:0]  exp_q, exp_d;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;
    logic              overflow_q, overflow_d;
    logic              all_done_q, all_done_d;

    logic full, pop, push, drop;

    assign full = (occ_q == OCC_W'(DEPTH));
    assign pop  = (state_q == StWrite) && mem_ack && !start;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push = in_valid && !start && (!full || pop);
    assign drop = in_valid && !start && full && !pop;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        exp_d      = exp_q;
        wr_count_d = wr_count_q;
        overflow_d = overflow_q | drop;
        all_done_d = all_done_q;

        if (start) begin
            state_d    = StIdle;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            occ_d      = '0;
            exp_d      = expected_count;
            wr_count_d = '0;
            overflow_d = 1'b0;
            all_done_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                if (wr_count_q != '1) begin
                    wr_count_d = wr_count_q + CNT_W'(1);
                end
            end
            unique case ({push, pop})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase

            unique case (state_q)
                StIdle:  if (occ_q != '0) state_d = StWrite;
                StWrite: if (pop) state_d = (occ_d != '0) ? StWrite : StIdle;
                default: state_d = StIdle;
            endcase

            if (wr_count_q == exp_q && occ_q == '0 && state_q == StIdle) begin
                all_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            exp_q      <= '0;
            wr_count_q <= '0;
            overflow_q <= 1'b0;
            all_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            exp_q      <= exp_d;
            wr_count_q <= wr_count_d;
            overflow_q <= overflow_d;
            all_done_q <= all_done_d;
        end
    end

    // Storage is cleared on reset so the head reads as zero before the first push.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (push) begin
            addr_q[wr_ptr_q] <= in_addr;
            data_q[wr_ptr_q] <= in_data;
        end
    end

    assign in_ready  = !full;
    assign mem_wr_en = (state_q == StWrite);
    assign mem_addr  = addr_q[rd_ptr_q];
    assign mem_wdata = data_q[rd_ptr_q];
    assign wr_count  = wr_count_q;
    assign overflow  = overflow_q;
    assign all_done  = all_done_q;

endmodule

// File: tb/tb_updatey_writeback.sv
// Bench for updatey_writeback: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_updatey_writeback;

    localparam int DATA_W = 48;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  expected_count = '0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic [ADDR_W-1:0] in_addr = '0;
    logic              in_ready;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack = 1'b0;
    logic [CNT_W-1:0]  wr_count;
    logic              overflow;
    logic              all_done;

    updatey_writeback #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .expected_count(expected_count),
        .in_valid(in_valid), .in_data(in_data), .in_addr(in_addr), .in_ready(in_ready),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .wr_count(wr_count), .overflow(overflow), .all_done(all_done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Reference model: a queue of pending writes plus pass bookkeeping.
    typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } ent_t;
    ent_t m_q[$];
    bit   m_busy, m_ovf, m_done;
    int   m_wrc, m_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy = 0; m_ovf = 0; m_done = 0; m_wrc = 0; m_exp = 0;
    endtask

    task automatic model_edge(input bit st, input int ev, input bit v,
                              input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input bit ack);
        int  pre_size;
        bit  pre_busy, pop, done_cond;
        ent_t e;
        if (st) begin
            model_reset();
            m_exp = ev;
            return;
        end
        pre_size  = m_q.size();
        pre_busy  = m_busy;
        done_cond = (m_wrc == m_exp) && (pre_size == 0) && !m_busy;
        pop = m_busy && ack;
        if (pop) begin
            void'(m_q.pop_front());
            if (m_wrc < (1 << CNT_W) - 1) m_wrc++;
        end
        if (v) begin
            if (pre_size < DEPTH || pop) begin
                e.a = a; e.d = d;
                m_q.push_back(e);
            end else begin
                m_ovf = 1;
            end
        end
        if (!pre_busy) m_busy = (pre_size > 0);
        else if (pop) m_busy = (m_q.size() > 0);
        if (done_cond) m_done = 1;
    endtask

    task automatic model_check(input string tag);
        chk({tag, ".wr_en"}, 64'(mem_wr_en), 64'(m_busy));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(m_q.size() < DEPTH));
        chk({tag, ".wr_count"}, 64'(wr_count), 64'(m_wrc));
        chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
        chk({tag, ".all_done"}, 64'(all_done), 64'(m_done));
        if (m_busy && m_q.size() > 0) begin
            chk({tag, ".addr"}, 64'(mem_addr), 64'(m_q[0].a));
            chk({tag, ".wdata"}, 64'(mem_wdata), 64'(m_q[0].d));
        end
    endtask

    task automatic cycle(input bit st, input int ev, input bit v, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input bit ack, input string tag);
        start = st; expected_count = CNT_W'(ev); in_valid = v; in_addr = a; in_data = d;
        mem_ack = ack;
        @(posedge clock);
        model_edge(st, ev, v, a, d, ack);
        #1;
        model_check(tag);
    endtask

    typedef struct {
        bit st; int ev; bit v; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; bit ack;
        bit e_en; logic [ADDR_W-1:0] e_addr; bit e_rdy; int e_wrc; bit e_ovf; bit e_done;
    } row_t;

    function automatic row_t mk(bit st, int ev, bit v, int a, bit ack,
                                bit en, int ea, bit rdy, int wrc, bit ovf, bit done);
        row_t r;
        r.st = st; r.ev = ev; r.v = v; r.a = ADDR_W'(a); r.ack = ack;
        r.d = 48'hA5A5_0000_0000 | 48'(a);
        r.e_en = en; r.e_addr = ADDR_W'(ea); r.e_rdy = rdy; r.e_wrc = wrc;
        r.e_ovf = ovf; r.e_done = done;
        return r;
    endfunction

    initial begin
        row_t rows[$];
        string tag;

        // Single write, fill/overflow, full push+pop with wrap, start mid-pass.
        rows.push_back(mk(1, 1, 0, 0,     1, 0, 0,     1, 0, 0, 0));
        rows.push_back(mk(0, 0, 1, 5,     1, 0, 0,     1, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0,     1, 1, 5,     1, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0,     1, 0, 0,     1, 1, 0, 0));
        rows.push_back(mk(0, 0, 0, 0,     1, 0, 0,     1, 1, 0, 1));
        rows.push_back(mk(1, 4, 0, 0,     0, 0, 0,     1, 0, 0, 0));
        rows.push_back(mk(0, 0, 1, 'h10,  0, 0, 0,     1, 0, 0, 0));
        rows.push_back(mk(0, 0, 1, 'h11,  0, 1, 'h10,  1, 0, 0, 0));
        rows.push_back(mk(0, 0, 1, 'h12,  0, 1, 'h10,  1, 0, 0, 0));
        rows.push_back(mk(0, 0, 1, 'h13,  0, 1, 'h10,  0, 0, 0, 0));
        rows.push_back(mk(0, 0, 1, 'h14,  0, 1, 'h10,  0, 0, 1, 0));
        rows.push_back(mk(0, 0, 0, 0,     1, 1, 'h11,  1, 1, 1, 0));
        rows.push_back(mk(0, 0, 0, 0,     1, 1, 'h12,  1, 2, 1, 0));
        rows.push_back(mk(0, 0, 0, 0,     1, 1, 'h13,  1, 3, 1, 0));
        rows.push_back(mk(0, 0, 0, 0,     1, 0, 0,     1, 4, 1, 0));
        rows.push_back(mk(0, 0, 0, 0,     0, 0, 0,     1, 4, 1, 1));
        rows.push_back(mk(1, 5, 0, 0,     0, 0, 0,     1, 0, 0, 0));
        rows.push_back(mk(0, 0, 1, 'h20,  0, 0, 0,     1, 0, 0, 0));
        rows.push_back(mk(0, 0, 1, 'h21,  0, 1, 'h20,  1, 0, 0, 0));
        rows.push_back(mk(0, 0, 1, 'h22,  0, 1, 'h20,  1, 0, 0, 0));
        rows.push_back(mk(0, 0, 1, 'h23,  0, 1, 'h20,  0, 0, 0, 0));
        rows.push_back(mk(0, 0, 1, 'h24,  1, 1, 'h21,  0, 1, 0, 0));
        rows.push_back(mk(0, 0, 0, 0,     1, 1, 'h22,  1, 2, 0, 0));
        rows.push_back(mk(0, 0, 0, 0,     1, 1, 'h23,  1, 3, 0, 0));
        rows.push_back(mk(0, 0, 0, 0,     1, 1, 'h24,  1, 4, 0, 0));
        rows.push_back(mk(0, 0, 0, 0,     1, 0, 0,     1, 5, 0, 0));
        rows.push_back(mk(0, 0, 0, 0,     0, 0, 0,     1, 5, 0, 1));
        rows.push_back(mk(1, 2, 0, 0,     0, 0, 0,     1, 0, 0, 0));
        rows.push_back(mk(0, 0, 1, 'h30,  0, 0, 0,     1, 0, 0, 0));
        rows.push_back(mk(0, 0, 1, 'h31,  0, 1, 'h30,  1, 0, 0, 0));
        rows.push_back(mk(1, 2, 1, 'h3F,  1, 0, 0,     1, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0,     1, 0, 0,     1, 0, 0, 0));
        rows.push_back(mk(0, 0, 1, 'h32,  1, 0, 0,     1, 0, 0, 0));
        rows.push_back(mk(0, 0, 1, 'h33,  1, 1, 'h32,  1, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0,     1, 1, 'h33,  1, 1, 0, 0));
        rows.push_back(mk(0, 0, 0, 0,     1, 0, 0,     1, 2, 0, 0));
        rows.push_back(mk(0, 0, 0, 0,     0, 0, 0,     1, 2, 0, 1));
        rows[1].d = 48'h00_1234_FF_FFFE;

        model_reset();
        #3;
        chk("reset.in_ready", 64'(in_ready), 64'd1);
        chk("reset.wr_en", 64'(mem_wr_en), 64'd0);
        chk("reset.addr", 64'(mem_addr), 64'd0);
        chk("reset.wdata", 64'(mem_wdata), 64'd0);
        chk("reset.wr_count", 64'(wr_count), 64'd0);
        chk("reset.overflow", 64'(overflow), 64'd0);
        chk("reset.all_done", 64'(all_done), 64'd0);
        @(posedge clock);
        #1 reset = 1'b1;

        for (int i = 0; i < rows.size(); i++) begin
            tag = $sformatf("row%0d", i);
            cycle(rows[i].st, rows[i].ev, rows[i].v, rows[i].a, rows[i].d, rows[i].ack, tag);
            chk({tag, ".tbl_en"}, 64'(mem_wr_en), 64'(rows[i].e_en));
            chk({tag, ".tbl_rdy"}, 64'(in_ready), 64'(rows[i].e_rdy));
            chk({tag, ".tbl_wrc"}, 64'(wr_count), 64'(rows[i].e_wrc));
            chk({tag, ".tbl_ovf"}, 64'(overflow), 64'(rows[i].e_ovf));
            chk({tag, ".tbl_done"}, 64'(all_done), 64'(rows[i].e_done));
            if (rows[i].e_en) chk({tag, ".tbl_addr"}, 64'(mem_addr), 64'(rows[i].e_addr));
        end
        chk("single.wdata_seen", 64'(m_wrc), 64'd2);

        // Wait states: ack every third cycle, order and head stability checked by the model.
        cycle(1, 3, 0, 0, 0, 0, "ws.start");
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, ADDR_W'(16'h40 + i), 48'h0BAD_0000_0000 + 48'(i * 7), 0, "ws.push");
        end
        for (int i = 0; i < 12; i++) cycle(0, 0, 0, 0, 0, (i % 3) == 2, "ws.drain");
        chk("ws.wr_count", 64'(wr_count), 64'd3);
        chk("ws.overflow", 64'(overflow), 64'd0);
        chk("ws.all_done", 64'(all_done), 64'd1);

        // Randomized traffic with occasional restarts.
        for (int i = 0; i < 400; i++) begin
            bit st;
            st = ($urandom_range(0, 99) < 3);
            cycle(st, $urandom_range(0, 8), $urandom_range(0, 99) < 55,
                  ADDR_W'($urandom()), 48'({$urandom(), $urandom()}),
                  $urandom_range(0, 99) < 60, "rnd");
        end

        // Async reset while a write is pending.
        cycle(1, 1, 0, 0, 0, 0, "ar.start");
        cycle(0, 0, 1, 10'h2AA, 48'hFEED_CAFE_0001, 0, "ar.push");
        cycle(0, 0, 0, 0, 0, 0, "ar.wait");
        chk("ar.pending", 64'(mem_wr_en), 64'd1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("ar.wr_en", 64'(mem_wr_en), 64'd0);
        chk("ar.in_ready", 64'(in_ready), 64'd1);
        chk("ar.addr", 64'(mem_addr), 64'd0);
        chk("ar.wdata", 64'(mem_wdata), 64'd0);
        chk("ar.wr_count", 64'(wr_count), 64'd0);
        chk("ar.overflow", 64'(overflow), 64'd0);
        chk("ar.all_done", 64'(all_done), 64'd0);
        @(posedge clock);
        #1 reset = 1'b1;
        cycle(0, 0, 0, 0, 0, 1, "ar.after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
